// File: rtl/ns_dac_pkg.sv
// ns_dac_pkg: shared types and sizing for the noise-shaping DAC path (modulator + PWM).
//   ns_order_t        : noise-shaping order selector (0th/1st/2nd order error feedback)
//   NS_*_BITS         : default widths of the pulse-width path
//   NS_ESAT_W         : width of the saturated quantization error registers
//   NS_INT_W          : signed width of the internal filter/quantizer datapath
//   ns_decode_order() : maps the raw 2-bit order input onto ns_order_t (3 behaves as 2)
package ns_dac_pkg;

    typedef enum logic [1:0] {
        NS_ORDER0 = 2'd0,
        NS_ORDER1 = 2'd1,
        NS_ORDER2 = 2'd2
    } ns_order_t;

    localparam int NS_OUT_BITS  = 11;
    localparam int NS_FRAC_BITS = 5;
    localparam int NS_OSR_BITS  = 4;
    localparam int NS_SAMPLE_W  = NS_OUT_BITS + NS_FRAC_BITS;
    localparam int NS_ESAT_W    = NS_FRAC_BITS + 2;
    localparam int NS_INT_W     = NS_OUT_BITS + NS_FRAC_BITS + 3;

    function automatic ns_order_t ns_decode_order(input logic [1:0] raw);
        case (raw)
            2'd0:    return NS_ORDER0;
            2'd1:    return NS_ORDER1;
            default: return NS_ORDER2;
        endcase
    endfunction

endpackage

// File: rtl/noise_shaping_modulator_if.sv
// noise_shaping_modulator_if: sample stream into the modulator.
//   in_sample : unsigned sample, LSB = 2^-FRAC_BITS pulse-width steps
//   in_valid  : master offers in_sample
//   in_ready  : slave can take a sample
// Handshake: a sample transfers on a clock edge where in_valid && in_ready; the master
// holds in_sample stable while in_valid is high and not yet accepted; in_ready may be
// high without in_valid and does not depend on in_valid.
interface noise_shaping_modulator_if #(
    parameter int SAMPLE_W = 16
) ();
    logic [SAMPLE_W-1:0] in_sample;
    logic                in_valid;
    logic                in_ready;

    modport master (output in_sample, output in_valid, input in_ready);
    modport slave  (input in_sample, input in_valid, output in_ready);
endinterface

// File: rtl/ns_lfsr_dither.sv
// ns_lfsr_dither: 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1) producing a
// signed 2-bit dither value in {-2..1} from its two LSBs. Advances only when step=1.
// Used by noise_shaping_modulator when NS_DITHER_EN is defined.
//   clk, reset : clock, synchronous active-high reset (reloads seed)
//   step       : advance the LFSR at this edge
//   dither     : current dither value (valid for the pulse being computed now)
module ns_lfsr_dither (
    input  logic              clk,
    input  logic              reset,
    input  logic              step,
    output logic signed [1:0] dither
);
    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [15:0] TAPS = 16'hB400;

    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (step) begin
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : 16'h0000);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) lfsr_q <= SEED;
        else       lfsr_q <= lfsr_d;
    end

    assign dither = $signed(lfsr_q[1:0]);
endmodule

// File: rtl/noise_shaping_modulator.sv
// noise_shaping_modulator: requantizes high-resolution unsigned samples into OUT_BITS-wide
// PWM pulse widths with 0th/1st/2nd-order error feedback. One new width per pulse_done.
// Optional build macro: NS_DITHER_EN adds LFSR dither (ns_lfsr_dither) to the quantizer input.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   order        : noise-shaping order 0/1/2 (3 treated as 2)
//   osr_log2     : each sample is used for 2^osr_log2 pulses
//   compare_max  : PWM period; output ceiling is compare_max+1
//   s_in         : sample stream (slave modport of noise_shaping_modulator_if)
//   pulse_done   : PWM finished a pulse; advance at this edge
//   pulse_width  : registered width to the PWM
//   underrun     : sticky, a sample boundary found the hold buffer empty
module noise_shaping_modulator
    import ns_dac_pkg::*;
#(
    parameter int OUT_BITS  = NS_OUT_BITS,
    parameter int FRAC_BITS = NS_FRAC_BITS,
    parameter int OSR_BITS  = NS_OSR_BITS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              order,
    input  logic [OSR_BITS-1:0]     osr_log2,
    input  logic [OUT_BITS-1:0]     compare_max,
    noise_shaping_modulator_if.slave s_in,
    input  logic                    pulse_done,
    output logic [OUT_BITS-1:0]     pulse_width,
    output logic                    underrun
);
    localparam int SAMPLE_W = OUT_BITS + FRAC_BITS;
    localparam int W        = SAMPLE_W + 3;
    localparam int ESAT_W   = FRAC_BITS + 2;
    // Large enough for the largest limit 2^(2^OSR_BITS-1)-1.
    localparam int RATE_W   = (1 << OSR_BITS) - 1;
    localparam logic signed [W-1:0] E_MAX = W'((1 << (ESAT_W - 1)) - 1);
    localparam logic signed [W-1:0] E_MIN = ~E_MAX;

    logic [SAMPLE_W-1:0]      cur_q, cur_d, hold_q, hold_d;
    logic                     hold_valid_q, hold_valid_d;
    logic [RATE_W-1:0]        rate_cnt_q, rate_cnt_d;
    logic signed [ESAT_W-1:0] e1_q, e1_d, e2_q, e2_d;
    logic [OUT_BITS-1:0]      pulse_width_q, pulse_width_d;
    logic                     underrun_q, underrun_d;

    logic signed [W-1:0]      e1_x, e2_x, fb, dith_x, v, q, y, e, ceil_s;
    logic signed [ESAT_W-1:0] e_sat;
    logic [OUT_BITS:0]        ceil_u;
    logic [RATE_W-1:0]        rate_lim;

`ifdef NS_DITHER_EN
    logic signed [1:0] dither;

    ns_lfsr_dither u_dither (
        .clk    (clk),
        .reset  (reset),
        .step   (pulse_done),
        .dither (dither)
    );

    assign dith_x = {{(W-2){dither[1]}}, dither};
`else
    assign dith_x = '0;
`endif

    // Filter + quantizer: purely combinational from the registered state so that the
    // width loaded at pulse_done reflects the current sample and error history.
    always_comb begin
        e1_x = {{(W-ESAT_W){e1_q[ESAT_W-1]}}, e1_q};
        e2_x = {{(W-ESAT_W){e2_q[ESAT_W-1]}}, e2_q};
        case (ns_decode_order(order))
            NS_ORDER0: fb = '0;
            NS_ORDER1: fb = e1_x;
            default:   fb = (e1_x <<< 1) - e2_x;
        endcase
        v      = $signed({{(W-SAMPLE_W){1'b0}}, cur_q}) + fb + dith_x;
        q      = v >>> FRAC_BITS;
        ceil_u = {1'b0, compare_max} + {{OUT_BITS{1'b0}}, 1'b1};
        ceil_s = $signed({{(W-OUT_BITS-1){1'b0}}, ceil_u});
        if (q[W-1])          y = '0;
        else if (q > ceil_s) y = ceil_s;
        else                 y = q;
        e = v - (y <<< FRAC_BITS);
        // Clamping can leave a large residual; saturate so the loop cannot run away.
        if (e > E_MAX)      e_sat = E_MAX[ESAT_W-1:0];
        else if (e < E_MIN) e_sat = E_MIN[ESAT_W-1:0];
        else                e_sat = e[ESAT_W-1:0];
    end

    // >= rather than == so that shrinking osr_log2 below the current count wraps at once.
    assign rate_lim = (RATE_W'(1) << osr_log2) - RATE_W'(1);

    always_comb begin
        cur_d         = cur_q;
        hold_d        = hold_q;
        hold_valid_d  = hold_valid_q;
        rate_cnt_d    = rate_cnt_q;
        e1_d          = e1_q;
        e2_d          = e2_q;
        pulse_width_d = pulse_width_q;
        underrun_d    = underrun_q;

        if (s_in.in_valid && !hold_valid_q) begin
            hold_d       = s_in.in_sample;
            hold_valid_d = 1'b1;
        end

        if (pulse_done) begin
            pulse_width_d = y[OUT_BITS-1:0];
            e2_d          = e1_q;
            e1_d          = e_sat;
            if (rate_cnt_q >= rate_lim) begin
                rate_cnt_d = '0;
                // No bypass: a sample accepted this same cycle only lands in hold.
                if (hold_valid_q) begin
                    cur_d        = hold_q;
                    hold_valid_d = 1'b0;
                end else begin
                    underrun_d = 1'b1;
                end
            end else begin
                rate_cnt_d = rate_cnt_q + RATE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_q         <= '0;
            hold_q        <= '0;
            hold_valid_q  <= 1'b0;
            rate_cnt_q    <= '0;
            e1_q          <= '0;
            e2_q          <= '0;
            pulse_width_q <= '0;
            underrun_q    <= 1'b0;
        end else begin
            cur_q         <= cur_d;
            hold_q        <= hold_d;
            hold_valid_q  <= hold_valid_d;
            rate_cnt_q    <= rate_cnt_d;
            e1_q          <= e1_d;
            e2_q          <= e2_d;
            pulse_width_q <= pulse_width_d;
            underrun_q    <= underrun_d;
        end
    end

    assign s_in.in_ready = !hold_valid_q;
    assign pulse_width   = pulse_width_q;
    assign underrun      = underrun_q;
endmodule
